// File: rtl/regfile_fwd.sv
// Parametrised register file with NUM_RD combinational read ports, one write port and a clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_fwd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    input  logic                       clr,
    output logic                       busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic                wr_ok;

    // Entry 0 is hardwired to zero when ZERO_REG is set.
    assign wr_ok = we && !((ZERO_REG != 0) && (wa == '0));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        mem_we  = 1'b0;
        mem_wa  = wa;
        mem_wd  = wd;
        case (state_q)
            IDLE: begin
                mem_we = wr_ok;
                if (clr) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = idx_q;
                mem_wd = '0;
                idx_d  = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: ;
        endcase
        if (rst) mem_we = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: the array has no reset; the clear sequencer zeroes it and busy masks reads meanwhile.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign busy = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        logic [DATA_W-1:0] rd_k;

        assign ra_k = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            if (busy_q)
                rd_k = '0;
            else if ((ZERO_REG != 0) && (ra_k == '0))
                rd_k = '0;
`ifdef REGFILE_BYPASS_EN
            else if (wr_ok && (ra_k == wa))
                rd_k = wd;
`endif
            else
                rd_k = mem_q[ra_k];
        end

        assign rd[k*DATA_W +: DATA_W] = rd_k;
    end

endmodule

// File: tb/tb_regfile_fwd.sv
// Self-checking bench for regfile_fwd: directed scenarios plus random traffic against a behavioural model.
// Build with or without REGFILE_BYPASS_EN to match the RTL configuration.
module tb_regfile_fwd;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int ZERO_REG = 1;
    localparam int DEPTH    = 2 ** ADDR_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     clr;
    logic                     busy;

    regfile_fwd #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
        .clr(clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: array contents plus the number of edges left until the file is usable again.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                sweep_left;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] port_rd(input int k);
        return rd[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(input int a);
        if (sweep_left != 0) return '0;
        if (ZERO_REG != 0 && a == 0) return '0;
        if (BYPASS && we && a == int'(wa) && !(ZERO_REG != 0 && wa == '0)) return wd;
        return ref_mem[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
            sweep_left = DEPTH;
        end else if (sweep_left != 0) begin
            sweep_left--;
        end else begin
            if (we && !(ZERO_REG != 0 && wa == '0)) ref_mem[wa] = wd;
            if (clr) begin
                foreach (ref_mem[i]) ref_mem[i] = '0;
                sweep_left = DEPTH;
            end
        end
    endtask

    // Check outputs for the current inputs, then clock one edge and advance the model.
    task automatic cycle();
        #1;
        check("busy", DATA_W'(busy), DATA_W'(sweep_left != 0));
        for (int k = 0; k < NUM_RD; k++)
            check($sformatf("rd%0d[a=%0d]", k, ra[k*ADDR_W +: ADDR_W]), port_rd(k),
                  exp_rd(int'(ra[k*ADDR_W +: ADDR_W])));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        we = 1'b1; wa = ADDR_W'(a); wd = d;
        cycle();
        we = 1'b0;
    endtask

    task automatic set_ra(input int k, input int a);
        ra[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            cycle();
            n++;
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i += NUM_RD) begin
            for (int k = 0; k < NUM_RD; k++) set_ra(k, (i + k) % DEPTH);
            cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; clr = 1'b0; ra = '0; wa = '0; wd = '0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        sweep_left = DEPTH;

        // Reset sweep: three edges of rst, then DEPTH edges to idle.
        @(posedge clk);
        model_edge();
        #1;
        repeat (2) cycle();
        rst = 1'b0;
        wait_idle(n);
        check("reset_sweep_len", DATA_W'(n), DATA_W'(DEPTH));
        read_all();

        // Basic write then read, and the hardwired zero entry.
        wr(5, 32'hDEADBEEF);
        wr(9, 32'h12345678);
        set_ra(0, 5); set_ra(1, 9);
        #1;
        check("read_5", port_rd(0), 32'hDEADBEEF);
        check("read_9", port_rd(1), 32'h12345678);
        cycle();
        wr(0, 32'hFFFFFFFF);
        set_ra(0, 0);
        #1;
        check("read_zero_reg", port_rd(0), 32'h0);
        cycle();

        // Same-cycle write/read of one address.
        wr(7, 32'h11);
        we = 1'b1; wa = 7; wd = 32'h22; set_ra(0, 7); set_ra(1, 7);
        #1;
        check("fwd_port0", port_rd(0), BYPASS ? 32'h22 : 32'h11);
        check("fwd_port1", port_rd(1), BYPASS ? 32'h22 : 32'h11);
        cycle();
        we = 1'b0;
        #1;
        check("after_wr_port0", port_rd(0), 32'h22);
        check("after_wr_port1", port_rd(1), 32'h22);
        cycle();

        // Clear request with a concurrent write, a second clr mid-sweep, and writes while busy.
        for (int i = 1; i < DEPTH; i++) wr(i, DATA_W'(i) * 32'h01010101 + 32'h100);
        clr = 1'b1; we = 1'b1; wa = 3; wd = 32'hAA;
        cycle();
        clr = 1'b0; we = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            clr = (n == 10);
            we = (n >= 15 && n < 20);
            wa = 4; wd = 32'h55;
            cycle();
            n++;
        end
        clr = 1'b0; we = 1'b0;
        check("clr_sweep_len", DATA_W'(n + 1), DATA_W'(DEPTH + 1));
        set_ra(0, 3); set_ra(1, 4);
        #1;
        check("cleared_3", port_rd(0), 32'h0);
        check("cleared_4", port_rd(1), 32'h0);
        read_all();

        // Reset in the middle of a clr sweep restarts the full sweep.
        wr(20, 32'hCAFEF00D);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        repeat (20) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wait_idle(n);
        check("rst_mid_sweep_len", DATA_W'(n), DATA_W'(DEPTH));
        read_all();

        // Random traffic, with reads biased toward the write address to exercise forwarding.
        repeat (3000) begin
            rst = ($urandom_range(0, 399) == 0);
            clr = ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 2) != 0);
            wa  = ADDR_W'($urandom_range(0, DEPTH - 1));
            wd  = DATA_W'($urandom);
            for (int k = 0; k < NUM_RD; k++)
                set_ra(k, ($urandom_range(0, 2) == 0) ? int'(wa) : int'($urandom_range(0, DEPTH - 1)));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
